// File: rtl/square_calculator.sv
// -----------------------------------------------------------------------------
// square_calculator
//
// Squares an unsigned WIDTH-bit operand with a serial shift-and-add multiplier.
// One partial product is added per clock, so a result takes WIDTH cycles after
// the start edge. The result and the done/error strobes are registered.
//
// Ports
//   clk    : single clock, rising edge
//   rst    : asynchronous reset, active low
//   start  : request pulse; `in` is sampled on the same edge
//   in     : WIDTH-bit unsigned operand
//   out    : 2*WIDTH-bit unsigned in*in, held until the next completion
//   done   : one-cycle completion strobe
//   error  : one-cycle strobe for a start that arrived while busy
//
// Build option
//   SQUARE_CALC_FAST_ZERO_EN : when defined, an accepted start with in == 0
//                              completes on the accepting edge (latency 1).
// -----------------------------------------------------------------------------
module square_calculator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in,
    output logic [2*WIDTH-1:0]   out,
    output logic                 done,
    output logic                 error
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last;

    // Partial product for the current multiplier bit and the running sum.
    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        partial = '0;
        if (mplier[cnt]) begin
            partial = {{WIDTH{1'b0}}, mcand} << cnt;
        end
        acc_next = acc + partial;
        last     = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register here is a plain flop (no RAM), so all of
            // them are reset; nothing relies on power-up values.
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            // Strobes are high for a single cycle unless re-asserted below.
            done  <= 1'b0;
            error <= 1'b0;

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= in;
                        mplier <= in;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef SQUARE_CALC_FAST_ZERO_EN
                        if (in == '0) begin
                            // Zero operand: the square is known, skip CALC.
                            state <= DONE;
                            out   <= '0;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    acc   <= acc_next;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    // A start while busy is rejected; the current job goes on.
                    error <= start;
                    if (last) begin
                        state <= DONE;
                        out   <= acc_next;
                        // done and error never share a cycle: a rejected start
                        // on the final edge takes precedence over the strobe.
                        done  <= !start;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
